// File: rtl/scmp_microcode_pak.sv
// ============================================================================
// Module      : scmp_microcode_pak
// Description : Shared constants and types for the SCMP microcode sequencer:
//               default parameter values, control-word bit indices and the
//               next-address source encoding.
//               Optional feature macro: SCMP_USEQ_STK_CHK_EN (sticky stack
//               overflow/underflow flags in scmp_useq).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scmp_microcode_pak;

  // Default sequencer geometry
  localparam int C_PC_W      = 8;
  localparam int C_NEXT_W    = 4;
  localparam int C_COND_W    = 10;
  localparam int C_STK_DEPTH = 4;

  // Bit positions of the sequencing controls inside a packed control word
  localparam int CTL_IX_DECODE   = 0;
  localparam int CTL_IX_RET      = 1;
  localparam int CTL_IX_CALL     = 2;
  localparam int CTL_IX_COND_JMP = 3;
  localparam int C_CTL_W         = 4;

  // Where the next microcode address comes from, in priority order
  typedef enum logic [2:0] {
    NXT_DECODE = 3'd0,
    NXT_RET    = 3'd1,
    NXT_COND   = 3'd2,
    NXT_ZERO   = 3'd3,
    NXT_REL    = 3'd4
  } nxt_src_e;

endpackage : scmp_microcode_pak

`default_nettype wire

// File: rtl/scmp_useq_stack.sv
// ============================================================================
// Module      : scmp_useq_stack
// Description : Return-address stack for the microcode sequencer. Entry 0 is
//               always the top; pushes shift toward the bottom and a push on
//               a full stack drops the oldest entry. Entries at or above the
//               occupancy are kept at zero, so an empty stack reads as 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scmp_useq_stack #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DATA_W-1:0]          i_push_data,
  output logic [DATA_W-1:0]          o_top,
  output logic [$clog2(DEPTH):0]     o_sp,
  output logic                       o_ovf_stb,
  output logic                       o_unf_stb
);

  localparam int SP_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] r_stk [DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic              w_full;
  logic              w_empty;

  assign w_full  = (r_sp == SP_W'(DEPTH));
  assign w_empty = (r_sp == '0);

  // A pop on an empty stack yields address 0
  assign o_top     = w_empty ? '0 : r_stk[0];
  assign o_sp      = r_sp;
  // Push+pop together is a replace, so only a lone push can overflow
  assign o_ovf_stb = i_push & ~i_pop & w_full;
  assign o_unf_stb = i_pop & w_empty;

  // Stack storage and occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
      r_sp <= '0;
    end else if (i_push && i_pop && !w_empty) begin
      r_stk[0] <= i_push_data;
    end else if (i_push) begin
      // Also covers push+pop on empty: the pop has nothing to remove
      for (int i = DEPTH - 1; i > 0; i--) r_stk[i] <= r_stk[i-1];
      r_stk[0] <= i_push_data;
      if (!w_full) r_sp <= r_sp + SP_W'(1);
    end else if (i_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) r_stk[i] <= r_stk[i+1];
      r_stk[DEPTH-1] <= '0;
      if (!w_empty) r_sp <= r_sp - SP_W'(1);
    end
  end

endmodule : scmp_useq_stack

`default_nettype wire

// File: rtl/scmp_useq.sv
// ============================================================================
// Module      : scmp_useq
// Description : Microcode sequencer. Selects the next microcode address from
//               decode dispatch, subroutine return, conditional skip, or a
//               relative step, and maintains a return-address stack.
//               Define SCMP_USEQ_STK_CHK_EN to enable the sticky stk_ovf /
//               stk_unf flags; otherwise both outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scmp_useq
  import scmp_microcode_pak::*;
#(
  parameter int PC_W      = C_PC_W,
  parameter int NEXT_W    = C_NEXT_W,
  parameter int COND_W    = C_COND_W,
  parameter int STK_DEPTH = C_STK_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hold,
  input  logic [PC_W-1:0]              op_pc,
  input  logic [COND_W-1:0]            cond_in,
  input  logic [COND_W-1:0]            cond_xor,
  input  logic [COND_W-1:0]            cond_mask,
  input  logic                         ctl_decode,
  input  logic                         ctl_ret,
  input  logic                         ctl_call,
  input  logic                         ctl_cond_jmp,
  input  logic [NEXT_W-1:0]            nextpc,
  output logic [PC_W-1:0]              mc_pc,
  output logic                         cond,
  output logic [$clog2(STK_DEPTH):0]   sp,
  output logic                         stk_ovf,
  output logic                         stk_unf
);

  logic [C_CTL_W-1:0] w_ctl;
  logic [PC_W-1:0]    r_mc_pc;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_pc_rel;
  logic [PC_W-1:0]    w_stk_top;
  logic [PC_W-1:0]    w_nxt_pc;
  nxt_src_e           w_nxt_src;
  logic               w_cond;
  logic               w_push;
  logic               w_pop;
  logic               w_ovf_stb;
  logic               w_unf_stb;

  // Gather the controls into one control word indexed by the shared constants
  always_comb begin
    w_ctl                  = '0;
    w_ctl[CTL_IX_DECODE]   = ctl_decode;
    w_ctl[CTL_IX_RET]      = ctl_ret;
    w_ctl[CTL_IX_CALL]     = ctl_call;
    w_ctl[CTL_IX_COND_JMP] = ctl_cond_jmp;
  end

  // Condition is live regardless of hold; an all-zero mask yields 0
  assign w_cond = |((cond_in ^ cond_xor) & cond_mask);
  assign cond   = w_cond;

  // Address arithmetic wraps naturally at PC_W bits; nextpc is zero-extended
  assign w_pc_inc = r_mc_pc + PC_W'(1);
  assign w_pc_rel = r_mc_pc + PC_W'(nextpc);

  // Decode wins over return, so a return under decode leaves the stack alone
  assign w_push = ~hold & w_ctl[CTL_IX_CALL];
  assign w_pop  = ~hold & w_ctl[CTL_IX_RET] & ~w_ctl[CTL_IX_DECODE];

  // Priority selection of the next-address source
  always_comb begin
    w_nxt_src = NXT_REL;
    if (w_ctl[CTL_IX_DECODE])                 w_nxt_src = NXT_DECODE;
    else if (w_ctl[CTL_IX_RET])               w_nxt_src = NXT_RET;
    else if (w_ctl[CTL_IX_COND_JMP] && w_cond) w_nxt_src = NXT_COND;
    else if (nextpc == '0)                    w_nxt_src = NXT_ZERO;
  end

  // Next-address mux
  always_comb begin
    w_nxt_pc = w_pc_rel;
    case (w_nxt_src)
      NXT_DECODE: w_nxt_pc = op_pc;
      NXT_RET:    w_nxt_pc = w_stk_top;
      NXT_COND:   w_nxt_pc = w_pc_inc;
      NXT_ZERO:   w_nxt_pc = '0;
      default:    w_nxt_pc = w_pc_rel;
    endcase
  end

  // Microcode address register, frozen while hold is asserted
  always_ff @(posedge clk) begin
    if (rst)        r_mc_pc <= '0;
    else if (!hold) r_mc_pc <= w_nxt_pc;
  end

  assign mc_pc = r_mc_pc;

  scmp_useq_stack #(
    .DEPTH  (STK_DEPTH),
    .DATA_W (PC_W)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_top       (w_stk_top),
    .o_sp        (sp),
    .o_ovf_stb   (w_ovf_stb),
    .o_unf_stb   (w_unf_stb)
  );

`ifdef SCMP_USEQ_STK_CHK_EN
  logic r_stk_ovf;
  logic r_stk_unf;

  // Sticky stack error flags; strobes are already qualified by hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stk_ovf <= 1'b0;
      r_stk_unf <= 1'b0;
    end else begin
      if (w_ovf_stb) r_stk_ovf <= 1'b1;
      if (w_unf_stb) r_stk_unf <= 1'b1;
    end
  end

  assign stk_ovf = r_stk_ovf;
  assign stk_unf = r_stk_unf;
`else
  logic w_unused_stb;
  assign w_unused_stb = w_ovf_stb | w_unf_stb;
  assign stk_ovf      = 1'b0;
  assign stk_unf      = 1'b0;
`endif

endmodule : scmp_useq

`default_nettype wire

// File: tb/tb_scmp_useq.sv
// ============================================================================
// Module      : tb_scmp_useq
// Description : Self-checking bench for scmp_useq. Directed scenarios plus a
//               randomized phase, checked against a queue-based reference
//               model of the sequencer. Honours SCMP_USEQ_STK_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scmp_useq;

  localparam int PC_W   = 8;
  localparam int NEXT_W = 4;
  localparam int COND_W = 10;
  localparam int DEPTH  = 4;
  localparam int SP_W   = $clog2(DEPTH) + 1;

`ifdef SCMP_USEQ_STK_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic [PC_W-1:0]   op_pc;
  logic [COND_W-1:0] cond_in, cond_xor, cond_mask;
  logic              ctl_decode, ctl_ret, ctl_call, ctl_cond_jmp;
  logic [NEXT_W-1:0] nextpc;
  logic [PC_W-1:0]   mc_pc;
  logic              cond;
  logic [SP_W-1:0]   sp;
  logic              stk_ovf, stk_unf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];   // front = top of stack
  bit m_ovf, m_unf;

  scmp_useq #(
    .PC_W(PC_W), .NEXT_W(NEXT_W), .COND_W(COND_W), .STK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .op_pc(op_pc),
    .cond_in(cond_in), .cond_xor(cond_xor), .cond_mask(cond_mask),
    .ctl_decode(ctl_decode), .ctl_ret(ctl_ret), .ctl_call(ctl_call),
    .ctl_cond_jmp(ctl_cond_jmp), .nextpc(nextpc),
    .mc_pc(mc_pc), .cond(cond), .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Condition: any enabled bit whose raw flag differs from its inversion bit
  function automatic bit model_cond();
    bit c = 1'b0;
    for (int i = 0; i < COND_W; i++)
      if (cond_mask[i] && (cond_in[i] != cond_xor[i])) c = 1'b1;
    return c;
  endfunction

  task automatic model_step();
    int nxt;
    int top;
    if (rst) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      return;
    end
    if (hold) return;
    top = (m_stk.size() != 0) ? m_stk[0] : 0;
    if (ctl_decode)                      nxt = int'(op_pc);
    else if (ctl_ret)                    nxt = top;
    else if (ctl_cond_jmp && model_cond()) nxt = m_pc + 1;
    else if (nextpc == 0)                nxt = 0;
    else                                 nxt = m_pc + int'(nextpc);
    if (ctl_ret && !ctl_decode) begin
      if (m_stk.size() == 0) m_unf = 1;
      else void'(m_stk.pop_front());
    end
    if (ctl_call) begin
      m_stk.push_front((m_pc + 1) % (1 << PC_W));
      if (m_stk.size() > DEPTH) begin
        void'(m_stk.pop_back());
        m_ovf = 1;
      end
    end
    m_pc = nxt % (1 << PC_W);
  endtask

  // One clock: check cond, advance model, clock, compare all state outputs
  task automatic cyc(input string tag);
    #1;
    check({tag, ":cond"}, 32'(cond), 32'(model_cond()));
    model_step();
    @(posedge clk);
    #1;
    check({tag, ":pc"},  32'(mc_pc),   32'(m_pc));
    check({tag, ":sp"},  32'(sp),      32'(m_stk.size()));
    check({tag, ":ovf"}, 32'(stk_ovf), 32'(CHK & m_ovf));
    check({tag, ":unf"}, 32'(stk_unf), 32'(CHK & m_unf));
  endtask

  task automatic clr();
    rst = 0; hold = 0; op_pc = '0;
    ctl_decode = 0; ctl_ret = 0; ctl_call = 0; ctl_cond_jmp = 0;
    nextpc = '0;
  endtask

  task automatic decode_to(input logic [PC_W-1:0] a);
    clr(); ctl_decode = 1; op_pc = a; cyc("decode");
    clr();
  endtask

  initial begin
    clr();
    cond_in = '0; cond_xor = '0; cond_mask = '0;
    m_pc = 0; m_ovf = 0; m_unf = 0;

    // Reset state
    rst = 1; ctl_call = 1; hold = 1; cyc("reset");
    check("reset_pc", 32'(mc_pc), 32'h0);
    check("reset_sp", 32'(sp), 32'h0);
    clr();

    // Sequential stepping 0,1,2,3
    nextpc = 1;
    cyc("step1"); check("step1_pc", 32'(mc_pc), 32'h1);
    cyc("step2"); check("step2_pc", 32'(mc_pc), 32'h2);
    cyc("step3"); check("step3_pc", 32'(mc_pc), 32'h3);

    // Wrap: 0xFE + 3 -> 0x01
    decode_to(8'hFE);
    nextpc = 3; cyc("wrap");
    check("wrap_pc", 32'(mc_pc), 32'h01);

    // Conditional skip taken, then inverted (not taken -> relative step)
    decode_to(8'h10);
    cond_in = 10'h004; cond_mask = 10'h004; cond_xor = '0;
    ctl_cond_jmp = 1; nextpc = 5; #1;
    check("cond_true", 32'(cond), 32'h1);
    cyc("cjmp_taken"); check("cjmp_taken_pc", 32'(mc_pc), 32'h11);
    decode_to(8'h10);
    cond_xor = 10'h004; ctl_cond_jmp = 1; nextpc = 5; #1;
    check("cond_false", 32'(cond), 32'h0);
    cyc("cjmp_fall"); check("cjmp_fall_pc", 32'(mc_pc), 32'h15);
    cond_in = '0; cond_xor = '0; cond_mask = '0;

    // Nested calls from 0x20, 0x30, 0x40 then three returns
    decode_to(8'h20);
    ctl_call = 1; ctl_decode = 1; op_pc = 8'h30; cyc("call20");
    ctl_call = 1; ctl_decode = 1; op_pc = 8'h40; cyc("call30");
    ctl_call = 1; ctl_decode = 1; op_pc = 8'h50; cyc("call40");
    check("calls_sp", 32'(sp), 32'h3);
    clr(); ctl_ret = 1;
    cyc("ret1"); check("ret1_pc", 32'(mc_pc), 32'h41); check("ret1_sp", 32'(sp), 32'h2);
    cyc("ret2"); check("ret2_pc", 32'(mc_pc), 32'h31); check("ret2_sp", 32'(sp), 32'h1);
    cyc("ret3"); check("ret3_pc", 32'(mc_pc), 32'h21); check("ret3_sp", 32'(sp), 32'h0);

    // Overflow: five calls into a four-deep stack, then five returns
    clr(); ctl_call = 1; nextpc = 1;
    for (int i = 0; i < 5; i++) cyc("ovf_call");
    check("ovf_sp", 32'(sp), 32'h4);
    check("ovf_flag", 32'(stk_ovf), 32'(CHK));
    clr(); ctl_ret = 1;
    for (int i = 0; i < 4; i++) cyc("ovf_ret");
    check("ovf_ret4_pc", 32'(mc_pc), 32'h23);
    cyc("unf_ret");
    check("unf_pc", 32'(mc_pc), 32'h0);
    check("unf_sp", 32'(sp), 32'h0);
    check("unf_flag", 32'(stk_unf), 32'(CHK));
    clr(); rst = 1; cyc("flag_clear");
    check("flag_clear_ovf", 32'(stk_ovf), 32'h0);
    clr();

    // Hold during a call: nothing moves, cond stays live
    decode_to(8'h60);
    hold = 1; ctl_call = 1; nextpc = 1; cond_mask = 10'h3FF;
    for (int i = 0; i < 4; i++) begin
      cond_in = 10'($urandom);
      cyc("hold");
      check("hold_pc", 32'(mc_pc), 32'h60);
      check("hold_sp", 32'(sp), 32'h0);
    end
    cond_in = '0; cond_mask = '0;
    clr(); ctl_call = 1; nextpc = 1; cyc("post_hold_call");
    check("post_hold_sp", 32'(sp), 32'h1);

    // Decode overrides return; stack untouched
    clr(); ctl_decode = 1; ctl_ret = 1; op_pc = 8'h80; cyc("dec_ret");
    check("dec_ret_pc", 32'(mc_pc), 32'h80);
    check("dec_ret_sp", 32'(sp), 32'h1);

    // Reset mid-call discards the push
    clr(); ctl_call = 1; rst = 1; cyc("rst_call");
    check("rst_call_sp", 32'(sp), 32'h0);
    clr();

    // Randomized phase against the model
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      hold         = ($urandom_range(0, 7) == 0);
      ctl_decode   = ($urandom_range(0, 7) == 0);
      ctl_ret      = ($urandom_range(0, 4) == 0);
      ctl_call     = ($urandom_range(0, 3) == 0);
      ctl_cond_jmp = ($urandom_range(0, 2) == 0);
      nextpc       = NEXT_W'($urandom);
      op_pc        = PC_W'($urandom);
      cond_in      = COND_W'($urandom);
      cond_xor     = COND_W'($urandom);
      cond_mask    = ($urandom_range(0, 3) == 0) ? '0 : COND_W'($urandom);
      cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_scmp_useq

`default_nettype wire

// File: doc/scmp_useq.md
SCMP_USEQ -- requirements
Module: scmp_useq

Interface
REQ-001 SHALL have parameter PC_W, default 8, microcode address width.
REQ-002 SHALL have parameter NEXT_W, default 4, relative next-field width.
REQ-003 SHALL have parameter COND_W, default 10, condition vector width.
REQ-004 SHALL have parameter STK_DEPTH, default 4, return stack entries (power of two, >=2).
REQ-005 SHALL have ports:
  - clk  in  1  sole clock; one clock, all state on rising edge
  - rst  in  1  reset, synchronous, active-high
  - hold  in  1  freeze sequencer (bus wait)
  - op_pc  in  PC_W  decode dispatch address
  - cond_in  in  COND_W  raw condition flags
  - cond_xor  in  COND_W  per-bit inversion
  - cond_mask  in  COND_W  per-bit enable
  - ctl_decode, ctl_ret, ctl_call, ctl_cond_jmp  in  1 each  sequencing controls
  - nextpc  in  NEXT_W  unsigned relative step; 0 means "go to 0"
  - mc_pc  out  PC_W  current microcode address
  - cond  out  1  evaluated condition
  - sp  out  $clog2(STK_DEPTH)+1  stack occupancy
  - stk_ovf, stk_unf  out  1 each  sticky stack error flags

Function
REQ-006 cond SHALL be combinational: OR-reduce of ((cond_in XOR cond_xor) AND cond_mask); all-zero mask gives 0.
REQ-007 When hold=0, next mc_pc SHALL be chosen by strict priority: ctl_decode -> op_pc; ctl_ret -> popped stack top; ctl_cond_jmp AND cond -> mc_pc+1; nextpc==0 -> 0; else mc_pc+nextpc.
REQ-008 All mc_pc arithmetic SHALL wrap modulo 2^PC_W; nextpc is zero-extended.
REQ-009 mc_pc SHALL change one cycle after the controls are sampled; control inputs are combinational from the microcode ROM addressed by mc_pc.
REQ-010 ctl_call with hold=0 SHALL push mc_pc+1 (wrapped), independent of which REQ-007 branch is taken.
REQ-011 ctl_ret with hold=0 and ctl_decode=0 SHALL pop the top entry; ctl_ret is ignored for stack purposes when ctl_decode=1.
REQ-012 Simultaneous effective pop and push SHALL replace the top entry with mc_pc+1; sp unchanged; next mc_pc = old top.
REQ-013 Push with sp==STK_DEPTH SHALL discard the oldest entry, keep sp at STK_DEPTH, and store the new entry as top.
REQ-014 Pop with sp==0 SHALL load mc_pc=0, leave sp at 0.
REQ-015 hold=1 SHALL freeze mc_pc, stack contents, sp and flags; cond stays live.

Reset
REQ-016 rst=1 at a clock edge SHALL set mc_pc=0, sp=0, all stack entries=0, stk_ovf=0, stk_unf=0; rst overrides hold and every control.
REQ-017 Reset asserted mid-call or mid-return SHALL discard the in-flight push or pop.

Configuration
REQ-018 Macro SCMP_USEQ_STK_CHK_EN defined: stk_ovf SHALL set on REQ-013 and stk_unf on REQ-014. Both flags are sticky until rst.
REQ-019 SCMP_USEQ_STK_CHK_EN undefined: stk_ovf and stk_unf SHALL be constant 0; REQ-013 and REQ-014 behaviour is unchanged.

Structure
REQ-020 Control-bit index constants (CTL_IX_DECODE, CTL_IX_RET, CTL_IX_CALL, CTL_IX_COND_JMP) and default parameter constants SHALL live in scmp_microcode_pak.
REQ-021 The return stack SHALL be a separate sub-module scmp_useq_stack with push, pop, top, sp and overflow/underflow strobes.

Verification
REQ-022 The bench SHALL cover:
  - Reset, then nextpc=1 with no ctl for 3 cycles -> mc_pc 0,1,2,3.
  - mc_pc=0xFE, nextpc=3 -> mc_pc=0x01 (wrap).
  - cond_in=0x004, cond_mask=0x004, cond_xor=0, ctl_cond_jmp, nextpc=5 at pc=0x10 -> 0x11; cond_xor=0x004 -> 0x15.
  - Calls at pc 0x20, 0x30, 0x40 then three rets -> returns 0x41, 0x31, 0x21; sp 3,2,1,0.
  - With STK_DEPTH=4, 5 calls -> sp=4, stk_ovf=1 (macro on), fifth ret -> mc_pc=0, stk_unf=1; macro off -> both flags 0.
  - hold=1 for 4 cycles during call -> no push, mc_pc frozen; ctl_decode+ctl_ret with op_pc=0x80 -> mc_pc=0x80, sp unchanged.
